// File: rtl/posit_denormalize_pipe_pkg.sv
// posit_denormalize_pipe_pkg: field-width helpers shared by the posit decode pipeline.
package posit_denormalize_pipe_pkg;
  typedef enum logic {NORMAL, EXTENDED} pd_mode_e;
  function automatic int get_scale_width(input int n, input int es, input pd_mode_e mode);
    return $clog2(n - 1) + 1 + es + (mode == EXTENDED ? 1 : 0);
  endfunction
  function automatic int get_fraction_width(input int n, input int es, input pd_mode_e mode);
    int fw;
    fw = (mode == EXTENDED) ? n - 1 : n - 3 - es;
    return fw < 1 ? 1 : fw;
  endfunction
  // Inter-stage word: {en, sign, nar, zero, r, m, magnitude}
  function automatic int get_mid_width(input int n);
    return 4 + $clog2(n) + n;
  endfunction
endpackage

// File: rtl/posit_denorm_lane_stage.sv
// posit_denorm_lane_stage: combinational decode step for one lane; STAGE selects which step.
module posit_denorm_lane_stage
  import posit_denormalize_pipe_pkg::*;
#(
  parameter int N = 32,
  parameter int ES = 2,
  parameter int STAGE = 1,
  localparam int LW = $clog2(N),
  localparam int SW = get_scale_width(N, ES, NORMAL),
  localparam int FW = get_fraction_width(N, ES, NORMAL),
  localparam int MIDW = get_mid_width(N),
  localparam int IW = STAGE == 1 ? N + 1 : MIDW,
  localparam int OW = STAGE == 3 ? 3 + SW + FW : MIDW
) (
  input  logic [IW-1:0] d,
  output logic [OW-1:0] q
);
  localparam int ESW = ES > 0 ? ES : 1;
  typedef struct packed {logic en, sign, nar, zero, r; logic [LW-1:0] m; logic [N-2:0] mag;} mid_t;
  typedef struct packed {logic sign, nar, zero; logic [SW-1:0] scale; logic [FW-1:0] fraction;} lane_t;
  if (STAGE == 1) begin : g_s1
    mid_t o;
    logic [N-2:0] mag;
    logic rz;
    always_comb begin
      rz = ~|d[N-2:0];
      mag = d[N-1] ? -d[N-2:0] : d[N-2:0];
      o = '0;
      o.en = d[N];
      o.sign = d[N] & d[N-1];
      o.nar = o.sign & rz;
      o.zero = d[N] & ~d[N-1] & rz;
      o.mag = d[N] ? mag : '0;
      o.r = o.mag[N-2];
    end
    assign q = o;
  end else if (STAGE == 2) begin : g_s2
    mid_t i, o;
    logic [N-2:0] x;
    logic [LW-1:0] m;
    always_comb begin
      i = d;
      x = i.r ? ~i.mag : i.mag;
      m = LW'(N - 1);
      for (int b = 0; b < N - 1; b++) m = x[b] ? LW'(N - 2 - b) : m;
      o = i;
      o.m = m;
    end
    assign q = o;
  end else begin : g_s3
    mid_t i;
    lane_t o;
    logic [N-2:0] sh;
    logic [N+ES+FW-2:0] ext;
    logic [ESW-1:0] ex;
    logic [FW-1:0] fr;
    logic [SW-1:0] k, sc;
    logic special;
    always_comb begin
      i = d;
      sh = i.mag << (int'(i.m) + 1);
      // zero padding below the shifted bits covers truncated exponent/fraction
      ext = {sh, (ES + FW)'(0)};
      ex = ES > 0 ? ext[N+ES+FW-2 -: ESW] : '0;
      fr = ext[N+FW-2 -: FW];
      k = i.r ? SW'(i.m) - SW'(1) : SW'(0) - SW'(i.m);
      sc = (k << ES) | SW'(ex);
      special = ~i.en | i.nar | i.zero;
      o.sign = i.sign;
      o.nar = i.nar;
      o.zero = i.zero;
      o.scale = special ? '0 : sc;
      o.fraction = special ? '0 : fr;
    end
    assign q = o;
  end
endmodule

// File: rtl/posit_denormalize_pipe.sv
// posit_denormalize_pipe: three-stage multi-lane posit decoder with valid/ready flow and NaR counter.
module posit_denormalize_pipe
  import posit_denormalize_pipe_pkg::*;
#(
  parameter int POSIT_WIDTH = 32,
  parameter int POSIT_ES = 2,
  parameter int NUM_LANES = 4,
  parameter int CNT_WIDTH = 16,
  localparam int SW = get_scale_width(POSIT_WIDTH, POSIT_ES, NORMAL),
  localparam int FW = get_fraction_width(POSIT_WIDTH, POSIT_ES, NORMAL)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [NUM_LANES*POSIT_WIDTH-1:0] s_posit,
  input  logic [NUM_LANES-1:0]             s_lane_en,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [NUM_LANES-1:0]             m_sign,
  output logic [NUM_LANES-1:0]             m_nar,
  output logic [NUM_LANES-1:0]             m_zero,
  output logic [NUM_LANES*SW-1:0]          m_scale,
  output logic [NUM_LANES*FW-1:0]          m_fraction,
  output logic [NUM_LANES-1:0]             m_guard,
  output logic [NUM_LANES-1:0]             m_round,
  output logic [NUM_LANES-1:0]             m_sticky,
  input  logic                             cnt_clr,
  output logic [CNT_WIDTH-1:0]             nar_count
);
  localparam int N = POSIT_WIDTH;
  localparam int MW = get_mid_width(N);
  localparam int LANEW = 3 + SW + FW;
  localparam int CW = CNT_WIDTH + $clog2(NUM_LANES + 1);
  typedef struct packed {logic sign, nar, zero; logic [SW-1:0] scale; logic [FW-1:0] fraction;} pd_lane_t;
  logic v1, v2, v3, en1, en2, en3;
  logic [NUM_LANES-1:0][MW-1:0] c1, s1, c2, s2;
  logic [NUM_LANES-1:0][LANEW-1:0] c3, s3;
  logic [NUM_LANES-1:0] nar_in;
  logic [CW-1:0] sum;
  logic [CNT_WIDTH-1:0] cnt_next;
  assign en3 = ~v3 | m_ready;
  assign en2 = ~v2 | en3;
  assign en1 = ~v1 | en2;
  assign s_ready = en1;
  assign m_valid = v3;
  assign m_guard = '0;
  assign m_round = '0;
  assign m_sticky = '0;
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    pd_lane_t o;
    posit_denorm_lane_stage #(.N(N), .ES(POSIT_ES), .STAGE(1)) u_s1 (.d({s_lane_en[l], s_posit[l*N +: N]}), .q(c1[l]));
    posit_denorm_lane_stage #(.N(N), .ES(POSIT_ES), .STAGE(2)) u_s2 (.d(s1[l]), .q(c2[l]));
    posit_denorm_lane_stage #(.N(N), .ES(POSIT_ES), .STAGE(3)) u_s3 (.d(s2[l]), .q(c3[l]));
    assign nar_in[l] = c1[l][MW-3];
    assign o = s3[l];
    assign m_sign[l] = o.sign;
    assign m_nar[l] = o.nar;
    assign m_zero[l] = o.zero;
    assign m_scale[l*SW +: SW] = o.scale;
    assign m_fraction[l*FW +: FW] = o.fraction;
  end
  assign sum = CW'(nar_count) + CW'($countones(nar_in & {NUM_LANES{s_valid & s_ready}}));
  assign cnt_next = cnt_clr ? '0 : |sum[CW-1:CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      nar_count <= '0;
    end else begin
      if (en1) v1 <= s_valid;
      if (en2) v2 <= v1;
      if (en3) v3 <= v2;
      if (en1 & s_valid) s1 <= c1;
      if (en2 & v1) s2 <= c2;
      if (en3 & v2) s3 <= c3;
      nar_count <= cnt_next;
    end
  end
endmodule

// File: doc/posit_denormalize_pipe.md
# posit_denormalize_pipe

Pipelined, multi-lane posit decoder. Each accepted beat carries NUM_LANES posit words, and each word is split into sign, NaR, zero, scale and fraction fields. Input and output use valid/ready handshakes, throughput is one beat per cycle, and latency is fixed at three cycles. A saturating NaR event counter is included. The block sits between posit operand memories/streams and the arithmetic datapaths (adders, FMA, quire), replacing combinational per-operand decoders where timing closure at high posit widths requires registers.

## Interface
- POSIT_WIDTH, 32, posit word width N (>= 5)
- POSIT_ES, 2, exponent field width (>= 0)
- NUM_LANES, 4, independent posit words per beat (>= 1)
- CNT_WIDTH, 16, NaR counter width
- Derived: SW = get_scale_width(POSIT_WIDTH, POSIT_ES, NORMAL), FW = get_fraction_width(POSIT_WIDTH, POSIT_ES, NORMAL)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- s_valid  in  1  input beat valid
- s_ready  out  1  block can accept a beat
- s_posit  in  NUM_LANES*POSIT_WIDTH  lane i at bits [i*N +: N]
- s_lane_en  in  NUM_LANES  per-lane enable; disabled lanes decode as all-zero fields
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accepts
- m_sign, m_nar, m_zero  out  NUM_LANES each  per-lane flags
- m_scale  out  NUM_LANES*SW  signed two's-complement scale per lane
- m_fraction  out  NUM_LANES*FW  fraction without hidden bit, MSB-aligned
- m_guard, m_round, m_sticky  out  NUM_LANES each  tied 0
- cnt_clr  in  1  synchronous clear of NaR counter
- nar_count  out  CNT_WIDTH  saturating count of NaR lanes accepted

## Operation
- Stage 1 (register S1): capture sign; NaR = sign & rest zero; zero = ~sign & rest zero; magnitude = two's complement of the low N-1 bits when sign=1; regime polarity r = magnitude MSB.
- Stage 2 (S2): if r=1, invert the magnitude. Leading-one detect over N-1 bits gives run length m. k = m-1 if r=1, else -m.
- Stage 3 (S3): shift magnitude left by m+1 (drop regime and terminator). Exponent = top ES bits, zero-padded when truncated. scale = (k << ES) + exp, in SW bits. Fraction = next FW bits, zero-padded when truncated. If FW <= 0, fraction is 0.
- NaR or zero lane: scale=0, fraction=0, sign as decoded.
- Disabled lane (s_lane_en=0 at acceptance): all outputs 0 for that lane; lane enable travels with the beat.
- nar_count += popcount(enabled NaR lanes) on each S1 capture. Saturates at 2^CNT_WIDTH-1. If cnt_clr and an increment occur in the same cycle, clear wins and the result is 0.

## Timing
- Reset: all stage valids 0, m_valid=0, all m_* data 0, nar_count=0, s_ready=1 after reset release.
- Transfer happens when valid & ready are both high on a rising edge. Latency is 3 cycles from s transfer to m_valid (beat accepted at cycle t is on outputs at t+3 when never stalled).
- Each stage n advances when its successor is empty or advancing. s_ready = ~S1.valid | S1 advancing (combinational ready chain, no bubbles). Back-to-back beats are sustained at 1/cycle.
- While m_valid & ~m_ready, m_* fields hold stable. Once all 3 stages are full, s_ready=0.
- m_valid never drops without a handshake. s_ready has no combinational dependence on s_valid.
- Reset mid-operation flushes all in-flight beats, and nothing is emitted afterward.

## Structure
- Add to posit_defines: get_scale_width / get_fraction_width (existing). Add a pd_lane_t packed struct {sign, NaR, zero, scale, fraction} parameterised via localparams.
- Single sub-module: posit_denorm_lane_stage, one instance per lane per stage (generate loop). Reuse the existing LOD_N for leading-one detection.
- The handshake/valid chain and counter live in the top module, shared by all lanes.

## Test plan
- N=16, ES=1, NUM_LANES=4 (SW=6, FW=12). Lanes {0x4000,0x5000,0x6000,0x4800} -> scale {0,1,2,0}, fraction {0x000,0x000,0x000,0x800}, sign 0, m_valid exactly 3 cycles after acceptance.
- Lanes {0x8000,0x0000,0xC000,0x0001} -> lane0 NaR=1; lane1 zero=1; lane2 sign=1, scale 0; lane3 scale=-28 (0x24). nar_count=1.
- Stream 20 random beats with m_ready held at 1 -> one output per cycle, order and values match the reference model, s_ready constantly 1.
- Hold m_ready=0 for 6 cycles mid-stream -> s_ready drops after 3 beats are buffered. Outputs stay stable, no beat is lost or duplicated, and flow resumes 1/cycle when m_ready returns.
- s_lane_en=4'b0101 with all lanes 0x8000 -> lanes 1 and 3 output all-zero, nar_count += 2. With CNT_WIDTH=2, preload to 3 and send another -> stays 3. Assert cnt_clr on an increment cycle -> 0.
- Assert rst_n low with 3 beats in flight -> m_valid=0 and nar_count=0 immediately. After release, no stale beat appears.
